// File: rtl/fp_normalize_round.sv
// Post-add normalizer/rounder for the single-precision adder: renormalizes the raw sum,
// rounds to nearest-even and packs an IEEE-754 word behind a stall-as-a-whole pipeline.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Input capture rank, then classify/LZC, shift and round/pack ranks.
  logic        v0_q, sign0_q;
  logic [7:0]  exp0_q;
  logic [27:0] mant0_q;

  logic        v1_q, sign1_q, pass1_q, zero1_q, carry1_q;
  logic [4:0]  lzc1_q;
  logic [26:0] mant1_q;
  logic signed [9:0] exp1_q;

  logic        v2_q, sign2_q, force2_q, ovf2_q, unf2_q;
  logic [30:0] fres2_q;
  logic [25:0] mant2_q;
  logic signed [9:0] exp2_q;

  // Stage 1: classify and count leading zeros below the carry bit
  logic        pass1_d, zero1_d, carry1_d;
  logic [4:0]  lzc1_d;
  logic [26:0] mant1_d;
  logic signed [9:0] exp1_d;

  always_comb begin
    pass1_d  = (exp0_q == 8'hFF);
    zero1_d  = (mant0_q == '0);
    carry1_d = mant0_q[27];
    lzc1_d   = '0;
    for (int i = 0; i < 27; i++) begin
      if (mant0_q[i]) lzc1_d = 5'(26 - i);
    end
    mant1_d = mant0_q[26:0];
    exp1_d  = signed'({2'b00, exp0_q});
    if (carry1_d && !pass1_d) begin
      mant1_d = {mant0_q[27:2], mant0_q[1] | mant0_q[0]};
      exp1_d  = exp1_d + 10'sd1;
    end
  end

  // Stage 2: special cases resolve here to a fixed result; normal values get left-shifted
  logic        force2_d, ovf2_d, unf2_d;
  logic [30:0] fres2_d;
  logic [25:0] mant2_d;
  logic signed [9:0] exp2_d, lzc_ext;

  assign lzc_ext = signed'({5'b00000, lzc1_q});

  always_comb begin
    force2_d = 1'b0;
    ovf2_d   = 1'b0;
    unf2_d   = 1'b0;
    fres2_d  = '0;
    mant2_d  = mant1_q[25:0];
    exp2_d   = exp1_q;
    if (pass1_q) begin
      force2_d = 1'b1;
      fres2_d  = {8'hFF, mant1_q[25:3]};
    end else if (zero1_q) begin
      force2_d = 1'b1;
    end else if (carry1_q) begin
      if (exp1_q >= 10'sd255) begin
        force2_d = 1'b1;
        ovf2_d   = 1'b1;
        fres2_d  = {8'hFF, 23'd0};
      end
    end else if (exp1_q <= lzc_ext) begin
      force2_d = 1'b1;
      unf2_d   = 1'b1;
    end else begin
      mant2_d = 26'(mant1_q << lzc1_q);
      exp2_d  = exp1_q - lzc_ext;
    end
  end

  // Stage 3: round to nearest even; a carry out of the fraction means significand 1.0
  logic        g3, rs3, inc3, ovf3_d, unf3_d, inex3_d;
  logic [23:0] frac_sum;
  logic [31:0] res3_d;
  logic signed [9:0] exp3;

  always_comb begin
    g3       = mant2_q[2];
    rs3      = mant2_q[1] | mant2_q[0];
    inc3     = g3 & (rs3 | mant2_q[3]);
    frac_sum = {1'b0, mant2_q[25:3]} + {23'd0, inc3};
    exp3     = exp2_q + (frac_sum[23] ? 10'sd1 : 10'sd0);
    ovf3_d   = 1'b0;
    unf3_d   = 1'b0;
    inex3_d  = g3 | rs3;
    res3_d   = {sign2_q, exp3[7:0], frac_sum[22:0]};
    if (force2_q) begin
      res3_d  = {sign2_q, fres2_q};
      ovf3_d  = ovf2_q;
      unf3_d  = unf2_q;
      inex3_d = ovf2_q | unf2_q;
    end else if (exp3 >= 10'sd255) begin
      res3_d  = {sign2_q, 8'hFF, 23'd0};
      ovf3_d  = 1'b1;
      inex3_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;  sign0_q <= 1'b0;  exp0_q <= '0;  mant0_q <= '0;
      v1_q <= 1'b0;  sign1_q <= 1'b0;  pass1_q <= 1'b0;  zero1_q <= 1'b0;  carry1_q <= 1'b0;
      lzc1_q <= '0;  mant1_q <= '0;  exp1_q <= '0;
      v2_q <= 1'b0;  sign2_q <= 1'b0;  force2_q <= 1'b0;  ovf2_q <= 1'b0;  unf2_q <= 1'b0;
      fres2_q <= '0;  mant2_q <= '0;  exp2_q <= '0;
      out_valid <= 1'b0;  out_result <= '0;
      out_ovf <= 1'b0;  out_unf <= 1'b0;  out_inexact <= 1'b0;
    end else if (advance) begin
      v0_q     <= in_valid;
      sign0_q  <= in_sign;
      exp0_q   <= in_exp;
      mant0_q  <= in_mant;
      v1_q     <= v0_q;
      sign1_q  <= sign0_q;
      pass1_q  <= pass1_d;
      zero1_q  <= zero1_d;
      carry1_q <= carry1_d;
      lzc1_q   <= lzc1_d;
      mant1_q  <= mant1_d;
      exp1_q   <= exp1_d;
      v2_q     <= v1_q;
      sign2_q  <= sign1_q;
      force2_q <= force2_d;
      ovf2_q   <= ovf2_d;
      unf2_q   <= unf2_d;
      fres2_q  <= fres2_d;
      mant2_q  <= mant2_d;
      exp2_q   <= exp2_d;
      out_valid   <= v2_q;
      out_result  <= res3_d;
      out_ovf     <= ovf3_d;
      out_unf     <= unf3_d;
      out_inexact <= inex3_d;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: expected words are queued on input acceptance
// and compared in order as results leave the pipe.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_inexact;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pushed = 0;
  int          n_popped = 0;
  int          ready_mode = 0;
  logic [34:0] sb[$];
  logic        ref_valid;
  logic [34:0] ref_val;

  always #5 clk = ~clk;

  fp_normalize_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_inexact(out_inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Reference: {ovf, unf, inexact, result}
  function automatic logic [34:0] model(input logic s, input logic [7:0] e8, input logic [27:0] mi);
    int          e;
    logic [27:0] m;
    logic [24:0] sig;
    logic        g, r, st;
    if (e8 == 8'hFF) return {3'b000, s, 8'hFF, mi[25:3]};
    if (mi == 28'd0) return {3'b000, s, 31'd0};
    e = int'(e8);
    m = mi;
    if (m[27]) begin
      st = m[1] | m[0];
      m = m >> 1;
      m[0] = st;
      e++;
      if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
    end else begin
      while (!m[26]) begin
        m = m << 1;
        e--;
      end
      if (e <= 0) return {3'b011, s, 31'd0};
    end
    g = m[2];
    r = m[1];
    st = m[0];
    sig = {1'b0, m[26:3]};
    if (g && (r || st || sig[0])) sig = sig + 25'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
    return {2'b00, g | r | st, s, e[7:0], sig[22:0]};
  endfunction

  // Sample handshakes mid-cycle; values are those the next rising edge acts on
  always @(negedge clk) begin
    logic [34:0] want;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(ref_valid ? ref_val : model(in_sign, in_exp, in_mant));
        n_pushed++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_count", 64'(n_popped + 1), 64'(n_pushed));
        end else begin
          want = sb.pop_front();
          n_popped++;
          check("result", 64'({out_ovf, out_unf, out_inexact, out_result}), 64'(want));
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic drive_beat(input logic s, input logic [7:0] e, input logic [27:0] m,
                            input logic has_ref, input logic [34:0] rv);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sign = s;
    in_exp = e;
    in_mant = m;
    ref_valid = has_ref;
    ref_val = rv;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = '0;
    in_mant = '0;
    ref_valid = 1'b0;
    ref_val = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Carry normalize with latency measurement on an empty pipe
    drive_beat(1'b0, 8'h7F, 28'hC000000, 1'b1, {3'b000, 32'h40400000});
    idle();
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    check("latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    drain();

    // Directed corner cases, back to back
    drive_beat(1'b0, 8'h85, 28'h0100000, 1'b1, {3'b000, 32'h3F800000});
    drive_beat(1'b0, 8'h7F, 28'h4000004, 1'b1, {3'b001, 32'h3F800000});
    drive_beat(1'b0, 8'h7F, 28'h400000C, 1'b1, {3'b001, 32'h3F800002});
    drive_beat(1'b0, 8'hFE, 28'h7FFFFFC, 1'b1, {3'b101, 32'h7F800000});
    drive_beat(1'b1, 8'h03, 28'h0000800, 1'b1, {3'b011, 32'h80000000});
    drive_beat(1'b0, 8'h03, 28'h0000000, 1'b1, {3'b000, 32'h00000000});
    drive_beat(1'b1, 8'h40, 28'h0000000, 1'b1, {3'b000, 32'h80000000});
    drive_beat(1'b1, 8'hFF, 28'h4400008, 1'b1, {3'b000, 32'hFF880001});
    drive_beat(1'b0, 8'hFE, 28'h8000000, 1'b1, {3'b101, 32'h7F800000});
    drive_beat(1'b0, 8'h00, 28'h4000000, 1'b1, {3'b011, 32'h00000000});
    idle();
    drain();

    // Four back-to-back beats, then a two-cycle output stall with a fifth beat waiting
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'(i), 8'(8'h80 + i), 28'h6A5C3F1 >> i, 1'b0, '0);
    end
    in_sign = 1'b1;
    in_exp = 8'h90;
    in_mant = 28'h2345678;
    ref_valid = 1'b0;
    in_valid = 1'b1;
    ready_mode = 1;
    repeat (2) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    drive_beat(1'b1, 8'h90, 28'h2345678, 1'b0, '0);
    idle();
    drain();
    check("stream_count", 64'(n_popped), 64'(n_pushed));

    // Reset with two beats in flight, one of them held at the output
    ready_mode = 1;
    drive_beat(1'b0, 8'h7F, 28'hC000000, 1'b0, '0);
    drive_beat(1'b1, 8'h80, 28'h0100000, 1'b0, '0);
    idle();
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_result", 64'(out_result), 64'd0);
    check("midrst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'd0);
    n_pushed -= sb.size();
    sb.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", 64'(in_ready), 64'd1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("dropped_beats", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       e = 8'($urandom_range(0, 6));
        1:       e = 8'hFF;
        2:       e = 8'($urandom_range(252, 254));
        default: e = 8'($urandom_range(1, 254));
      endcase
      m = 28'($urandom) >> $urandom_range(0, 28);
      drive_beat(s, e, m, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    ready_mode = 0;
    drain();
    check("final_count", 64'(n_popped), 64'(n_pushed));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
